// File: rtl/puf_ctrl_pkg.sv
// Shared types and defaults for the arbiter-PUF challenge sequencer.
package puf_ctrl_pkg;

  localparam int DEF_CHAL_W        = 65;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_NUM_EVALS     = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    LAUNCH  = 3'd2,
    SAMPLE  = 3'd3,
    RELEASE = 3'd4,
    RESP    = 3'd5
  } puf_state_t;

  // Majority threshold: the response is 1 when more than half the samples read 1.
  function automatic int half_evals(input int num_evals);
    return num_evals / 2;
  endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for the asynchronous arbiter output.
module puf_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs NUM_EVALS launch/sample/release cycles on an arbiter PUF per request
// and returns the majority-voted response bit over a valid/ready handshake.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W        = DEF_CHAL_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_EVALS     = DEF_NUM_EVALS,
  parameter int CNT_W         = $clog2(NUM_EVALS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic [CNT_W-1:0]  rsp_ones,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_launch,
  input  logic              puf_resp,
  output logic              busy
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int HALF  = half_evals(NUM_EVALS);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LAST   = CNT_W'(NUM_EVALS - 1);
  localparam logic [CNT_W-1:0] ONES_MAX    = CNT_W'(NUM_EVALS);
  localparam logic [CNT_W-1:0] ONES_HALF   = CNT_W'(HALF);

  puf_state_t        r_state;
  puf_state_t        w_state_nxt;
  logic [CHAL_W-1:0] r_chal;
  logic [CNT_W-1:0]  r_ones;
  logic [CNT_W-1:0]  r_eval_cnt;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_launch;
  logic              r_rsp_valid;
  logic              r_rsp_bit;
  logic [CNT_W-1:0]  r_rsp_ones;
  logic              w_resp_sync;
  logic              w_settle_done;
  logic              w_eval_last;
  logic              w_accept;
  logic              w_settling;

  puf_resp_sync u_resp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (puf_resp),
    .o_q   (w_resp_sync)
  );

  assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
  assign w_eval_last   = (r_eval_cnt == EVAL_LAST);
  assign w_accept      = (r_state == IDLE) && req_valid;
  assign w_settling    = (r_state == LAUNCH) || (r_state == RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = LAUNCH;
      LAUNCH:  if (w_settle_done) w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = RELEASE;
      RELEASE: if (w_settle_done) w_state_nxt = w_eval_last ? RESP : LAUNCH;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Launch is registered off the next state so the race paths see a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_launch     <= 1'b0;
      r_settle_cnt <= '0;
      r_chal       <= '0;
      r_ones       <= '0;
      r_eval_cnt   <= '0;
    end else begin
      r_launch <= (w_state_nxt == LAUNCH) || (w_state_nxt == SAMPLE);

      if (w_settling && !w_settle_done) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end else begin
        r_settle_cnt <= '0;
      end

      if (w_accept) begin
        r_chal     <= req_chal;
        r_ones     <= '0;
        r_eval_cnt <= '0;
      end

      if ((r_state == SAMPLE) && (r_ones != ONES_MAX)) begin
        r_ones <= r_ones + CNT_W'(w_resp_sync);
      end

      if ((r_state == RELEASE) && w_settle_done && !w_eval_last) begin
        r_eval_cnt <= r_eval_cnt + 1'b1;
      end
    end
  end

  // Response fields are captured on entry to RESP and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_bit   <= 1'b0;
      r_rsp_ones  <= '0;
    end else if ((w_state_nxt == RESP) && (r_state != RESP)) begin
      r_rsp_valid <= 1'b1;
      r_rsp_bit   <= (r_ones > ONES_HALF);
      r_rsp_ones  <= r_ones;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_bit    = r_rsp_bit;
  assign rsp_ones   = r_rsp_ones;
  assign puf_chal   = r_chal;
  assign puf_launch = r_launch;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: cycle-offset reference model plus directed and random traffic.
module tb_puf_challenge_sequencer;

  localparam int CW  = 65;
  localparam int S   = 4;
  localparam int N   = 3;
  localparam int P   = 2 * S + 1;
  localparam int CNT = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [CW-1:0]  req_chal = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_bit;
  logic [CNT-1:0] rsp_ones;
  logic [CW-1:0]  puf_chal;
  logic           puf_launch;
  logic           puf_resp = 1'b0;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int n_rsp = 0;

  puf_challenge_sequencer #(
    .CHAL_W        (CW),
    .SETTLE_CYCLES (S),
    .NUM_EVALS     (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chal   (req_chal),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_bit    (rsp_bit),
    .rsp_ones   (rsp_ones),
    .puf_chal   (puf_chal),
    .puf_launch (puf_launch),
    .puf_resp   (puf_resp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks cycles elapsed since the accepting edge.
  // Sample for eval e is puf_resp as seen at edge accept+S+e*P (two-flop delay
  // ahead of the SAMPLE cycle); response appears at edge accept+1+N*P.
  bit            m_busy = 1'b0;
  bit            m_rsp_valid = 1'b0;
  int            m_t = 0;
  int            m_ones = 0;
  int            m_rsp_ones = 0;
  bit            m_rsp_bit = 1'b0;
  logic [CW-1:0] m_chal = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_rsp_valid = 1'b0; m_t = 0; m_ones = 0;
      m_rsp_ones = 0; m_rsp_bit = 1'b0; m_chal = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1; m_t = 0; m_ones = 0; m_chal = req_chal;
      end
    end else if (m_rsp_valid) begin
      if (rsp_ready) begin
        m_rsp_valid = 1'b0; m_busy = 1'b0;
      end
    end else begin
      m_t = m_t + 1;
      if (m_t >= S && ((m_t - S) % P) == 0 && ((m_t - S) / P) < N && puf_resp)
        m_ones = m_ones + 1;
      if (m_t == 1 + N * P) begin
        m_rsp_valid = 1'b1;
        m_rsp_ones  = m_ones;
        m_rsp_bit   = (m_ones > N / 2);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_chal(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit exp_launch;
    exp_launch = m_busy && !m_rsp_valid && m_t >= 1 && m_t <= N * P && ((m_t - 1) % P) <= S;
    chk("cmp_req_ready", int'(req_ready), int'(!m_busy));
    chk("cmp_busy", int'(busy), int'(m_busy));
    chk("cmp_rsp_valid", int'(rsp_valid), int'(m_rsp_valid));
    chk("cmp_rsp_bit", int'(rsp_bit), int'(m_rsp_bit));
    chk("cmp_rsp_ones", int'(rsp_ones), m_rsp_ones);
    chk("cmp_launch", int'(puf_launch), int'(exp_launch));
    chk_chal("cmp_puf_chal", puf_chal, m_chal);
  endtask

  // Drives one request; puf_resp follows pat[e] per evaluation, switching during RELEASE.
  task automatic run_txn(input logic [CW-1:0] chal, input logic [2:0] pat, input bit glitch,
                         input bit rej, output int lat, output int highs, output int rises);
    int  c;
    int  e;
    bit  prev;
    @(negedge clk);
    req_valid = 1'b1; req_chal = chal; puf_resp = pat[0];
    @(negedge clk);
    req_valid = 1'b0;
    chk_chal("chal_after_accept", puf_chal, chal);
    c = 0; lat = -1; highs = 0; rises = 0; prev = 1'b0;
    while (lat < 0 && c < 200) begin
      if (puf_launch) highs++;
      if (puf_launch && !prev) rises++;
      prev = puf_launch;
      if (rsp_valid) lat = c;
      e = (c + 3) / P;
      if (e > N - 1) e = N - 1;
      puf_resp = pat[e];
      if (glitch && c == S) puf_resp = 1'b0;
      if (rej && c == 2) begin
        req_valid = 1'b1; req_chal = ~chal;
      end
      if (rej && c == 3) begin
        req_valid = 1'b0;
        chk("rej_req_ready", int'(req_ready), 0);
        chk_chal("rej_puf_chal", puf_chal, chal);
      end
      if (lat < 0) begin
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic finish_rsp(input string nm, input int hold, input int exp_ones, input int exp_bit);
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_valid"}, int'(rsp_valid), 1);
      chk({nm, "_hold_ones"}, int'(rsp_ones), exp_ones);
      chk({nm, "_hold_bit"}, int'(rsp_bit), exp_bit);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_post_req_ready"}, int'(req_ready), 1);
    chk({nm, "_post_rsp_valid"}, int'(rsp_valid), 0);
    chk({nm, "_post_ones_held"}, int'(rsp_ones), exp_ones);
  endtask

  initial begin
    fork
      begin : compare_proc
        bit prev_v;
        prev_v = 1'b0;
        forever begin
          @(negedge clk);
          compare_cycle();
          if (rsp_valid && !prev_v) n_rsp++;
          prev_v = rsp_valid;
        end
      end
      begin : stim_proc
        int lat, highs, rises, base;
        logic [95:0]   rnd;
        logic [CW-1:0] chal_a;
        chal_a = 65'h1_A5A5_0000_FFFF_1234;

        #1 rst_n = 1'b0;
        req_valid = 1'b1; req_chal = chal_a;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_bit", int'(rsp_bit), 0);
        chk("rst_rsp_ones", int'(rsp_ones), 0);
        chk("rst_launch", int'(puf_launch), 0);
        chk_chal("rst_puf_chal", puf_chal, '0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(chal_a, 3'b111, 1'b0, 1'b0, lat, highs, rises);
        chk("one_latency", lat, 28);
        chk("one_launch_high_cycles", highs, 15);
        chk("one_launch_pulses", rises, 3);
        chk("one_rsp_ones", int'(rsp_ones), 3);
        chk("one_rsp_bit", int'(rsp_bit), 1);
        finish_rsp("one", 10, 3, 1);

        run_txn(~chal_a, 3'b101, 1'b0, 1'b0, lat, highs, rises);
        chk("noisy101_latency", lat, 28);
        chk("noisy101_ones", int'(rsp_ones), 2);
        chk("noisy101_bit", int'(rsp_bit), 1);
        finish_rsp("noisy101", 1, 2, 1);

        run_txn(chal_a ^ 65'h5, 3'b010, 1'b0, 1'b0, lat, highs, rises);
        chk("noisy010_ones", int'(rsp_ones), 1);
        chk("noisy010_bit", int'(rsp_bit), 0);
        finish_rsp("noisy010", 2, 1, 0);

        run_txn(chal_a, 3'b111, 1'b1, 1'b0, lat, highs, rises);
        chk("glitch_ones", int'(rsp_ones), 3);
        chk("glitch_bit", int'(rsp_bit), 1);
        finish_rsp("glitch", 1, 3, 1);

        base = n_rsp;
        run_txn(65'h0_1234_5678_9ABC_DEF0, 3'b001, 1'b0, 1'b1, lat, highs, rises);
        chk("rej_latency", lat, 28);
        chk("rej_ones", int'(rsp_ones), 1);
        finish_rsp("rej", 1, 1, 0);
        repeat (40) @(negedge clk);
        chk("rej_single_response", n_rsp - base, 1);

        // Reset while the first launch pulse is high.
        base = n_rsp;
        @(negedge clk);
        req_valid = 1'b1; req_chal = chal_a; puf_resp = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_launch", int'(puf_launch), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_launch", int'(puf_launch), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_no_response", n_rsp - base, 0);
        chk("rst_idle_ready", int'(req_ready), 1);

        base = n_rsp;
        for (int cyc = 0; cyc < 1500; cyc++) begin
          rnd = {$urandom(), $urandom(), $urandom()};
          req_chal  = rnd[CW-1:0];
          req_valid = ($urandom_range(3) == 0);
          rsp_ready = ($urandom_range(2) == 0);
          if ($urandom_range(3) == 0) puf_resp = ~puf_resp;
          @(negedge clk);
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        chk("rand_progress", int'((n_rsp - base) >= 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Sequences one arbiter-chain PUF evaluation per host request.
- Per request: latches a challenge and drives it onto the stage selects, then fires the launch edge into both race paths.
- Waits a programmable settle time, samples the arbiter output through a synchronizer, then drops launch and waits for the paths to discharge.
- Repeats NUM_EVALS times, majority-votes the samples, and returns one response bit over a valid/ready handshake.
- Sits between the host or test controller and the PUF delay chain.

Parameters:
- CHAL_W, 65: challenge width; one select bit per mux stage.
- SETTLE_CYCLES, 16: clk cycles launch is held before sampling, and also the low time before the next launch. Minimum 3.
- NUM_EVALS, 15: repeated evaluations per challenge. Must be odd, 1..255.
- CNT_W, $clog2(NUM_EVALS+1): width of the ones counter.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: host presents a challenge.
- req_ready, output, 1: block can accept a challenge. High only in IDLE.
- req_chal, input, CHAL_W: challenge value.
- rsp_valid, output, 1: response available.
- rsp_ready, input, 1: host accepts the response.
- rsp_bit, output, 1: majority-voted PUF response.
- rsp_ones, output, CNT_W: count of samples that read 1.
- puf_chal, output, CHAL_W: stage select vector to the delay chain.
- puf_launch, output, 1: launch signal into both race paths.
- puf_resp, input, 1: arbiter output, asynchronous to clk.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_bit=0, rsp_ones=0, puf_chal=0, puf_launch=0, busy=0.
  - Eval counter, settle counter and synchronizer flops clear.
  - Reset mid-evaluation drops puf_launch immediately and discards the in-flight request; no response is produced.
- States, with every transition on a rising clk edge:
  - IDLE: req_ready=1. If req_valid, then puf_chal<=req_chal, ones<=0, eval_cnt<=0, and go to LOAD. A request is accepted only when req_valid && req_ready.
  - LOAD: one cycle so the challenge propagates to the mux selects; puf_launch=0. Go to LAUNCH; settle_cnt<=0.
  - LAUNCH: puf_launch=1. settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: puf_launch=1. ones<=ones+resp_sync. Go to RELEASE; settle_cnt<=0.
  - RELEASE: puf_launch=0. When settle_cnt==SETTLE_CYCLES-1:
    - if eval_cnt==NUM_EVALS-1, go to RESP;
    - otherwise eval_cnt<=eval_cnt+1 and go to LAUNCH.
  - RESP: rsp_valid=1; rsp_bit=(ones > NUM_EVALS/2); rsp_ones=ones. Both outputs are stable while rsp_valid && !rsp_ready. When rsp_ready, go to IDLE.
- Handshake rules:
  - rsp_valid and rsp_bit are registered. rsp_bit/rsp_ones hold their last value after the handshake until the next RESP.
  - req_valid during busy is ignored; req_ready=0 there.
  - puf_chal is constant from LOAD through RESP and is never changed while puf_launch=1.
- Latency:
  - Per evaluation: 2*SETTLE_CYCLES+1 cycles.
  - If the request is accepted at edge k, rsp_valid rises at edge k+1+NUM_EVALS*(2*SETTLE_CYCLES+1).
- Sampling:
  - resp_sync is puf_resp through two flops, so a level stable ≥2 cycles before SAMPLE is captured.
  - This 2-cycle synchronizer latency is the reason for SETTLE_CYCLES≥3.
- Arithmetic: ones saturates at NUM_EVALS (cannot overflow by construction); eval_cnt has width CNT_W.
- Simultaneous events: in the cycle a RESP handshake completes, req_ready is still 0, so a new request is accepted at the earliest one cycle later, in IDLE.

Decomposition:
- Package puf_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, LAUNCH, SETTLE-free set as listed: IDLE, LOAD, LAUNCH, SAMPLE, RELEASE, RESP);
  - the localparam HALF = NUM_EVALS/2 helper function;
  - the default parameter constants.
- Sub-module puf_resp_sync: a 2-flop synchronizer with async active-low clear, instantiated once on puf_resp.

Test Plan:
- Reset: assert rst_n=0 with a request pending → all outputs 0 except req_ready=1. Assert rst_n=0 during LAUNCH → puf_launch falls without waiting for clk, and no rsp_valid appears after release.
- Constant-one PUF: SETTLE_CYCLES=4, NUM_EVALS=3, req_chal=65'h1_A5A5_0000_FFFF_1234, puf_resp tied to 1; accept at edge k → rsp_valid at edge k+28, rsp_bit=1, rsp_ones=3. puf_chal equals the challenge from edge k onward, and puf_launch shows 3 pulses of 5 cycles high separated by 4 cycles low.
- Noisy PUF: same parameters; puf_resp driven 1,0,1 per evaluation (changing during RELEASE) → rsp_ones=2, rsp_bit=1. Pattern 0,1,0 → rsp_ones=1, rsp_bit=0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid, rsp_bit and rsp_ones hold. rsp_ready=1 → IDLE next cycle and req_ready=1.
- Busy rejection: pulse req_valid with a different challenge while in LAUNCH → req_ready=0, puf_chal unchanged, exactly one response produced.
- Late glitch: puf_resp toggles to 0 on the cycle before SAMPLE only → sample still reads 1, because the toggle has not yet passed the synchronizer.
